// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: FSM encoding, default
// cause codes, the mstatus MIE position and the machine-mode CSR addresses.
package trap_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTER    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_RET      = 2'd3
    } state_t;

    // Default mcause codes (low bits; interrupts also set the top bit)
    localparam int ECALL_CAUSE_DEF = 11;
    localparam int IRQ_CAUSE_DEF   = 7;

    // mstatus bit holding the global machine interrupt enable
    localparam int MSTATUS_MIE_BIT = 3;

    // mtvec MODE field encoding for vectored interrupts
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Machine-mode CSR addresses used by the neighbouring register block
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

endpackage

// File: rtl/trap_ctrl.sv
// Trap/return sequencer in front of the CSR block. Accepts an interrupt,
// ecall or mret at commit, strobes mepc/mcause/mstatus updates, then
// redirects fetch to mtvec (trap) or mepc (return) while stalling the core.
//
// Handshake: take is combinational and marks the accept cycle; busy is
// registered and stays high for every cycle the sequence runs, during which
// commit_valid is ignored. All strobes are single-cycle registered pulses.
//
// Optional build macro TRAP_CTRL_VECTORED_EN: honour mtvec MODE=01 for
// interrupts (target = base + 4*IRQ_CAUSE). Without it mtvec[1:0] is ignored.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = ECALL_CAUSE_DEF,
    parameter int IRQ_CAUSE   = IRQ_CAUSE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic            irq_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mstatus_i,
    output logic            take,
    output logic            busy,
    output logic            panic,
    output logic            wMepc,
    output logic [XLEN-1:0] mepc_v,
    output logic            wMcause,
    output logic [XLEN-1:0] mcause_v,
    output logic            pc_mret,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] IRQ_MCAUSE   = {1'b1, (XLEN-1)'(IRQ_CAUSE)};
    localparam logic [XLEN-1:0] ECALL_MCAUSE = XLEN'(ECALL_CAUSE);

    state_t          state;
    logic            irq_q;
    logic            irq_pending;
    logic            trap_is_irq;
    logic            irq_edge;
    logic            acc_irq;
    logic            acc_ecall;
    logic            acc_mret;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;
    logic            unused_mstatus;

    // Only MIE is consumed from mstatus
    assign unused_mstatus = ^{mstatus_i[XLEN-1:MSTATUS_MIE_BIT+1],
                              mstatus_i[MSTATUS_MIE_BIT-1:0]};

    // Accept decode: only in IDLE, interrupt beats ecall beats mret
    always_comb begin
        irq_edge  = irq_i & ~irq_q;
        acc_irq   = 1'b0;
        acc_ecall = 1'b0;
        acc_mret  = 1'b0;
        if (state == ST_IDLE && commit_valid) begin
            if (irq_pending && mstatus_i[MSTATUS_MIE_BIT]) begin
                acc_irq = 1'b1;
            end else if (is_ecall) begin
                acc_ecall = 1'b1;
            end else if (is_mret) begin
                acc_mret = 1'b1;
            end
        end
        take = acc_irq | acc_ecall | acc_mret;
    end

    // Trap vector: mtvec base, optionally offset for vectored interrupts
    always_comb begin
        trap_base = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
        if (trap_is_irq && mtvec_i[1:0] == MTVEC_MODE_VECTORED) begin
            trap_target = trap_base + (XLEN'(IRQ_CAUSE) << 2);
        end else begin
            trap_target = trap_base;
        end
`else
        trap_target = trap_base;
`endif
    end

`ifndef TRAP_CTRL_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^{mtvec_i[1:0], trap_is_irq};
`endif

    // Interrupt edge capture; a new edge in the take cycle keeps it pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q       <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_q       <= irq_i;
            irq_pending <= irq_edge | (irq_pending & ~acc_irq);
        end
    end

    // Sequencer FSM with registered strobes and redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            trap_is_irq    <= 1'b0;
            busy           <= 1'b0;
            panic          <= 1'b0;
            wMepc          <= 1'b0;
            wMcause        <= 1'b0;
            pc_mret        <= 1'b0;
            redirect_valid <= 1'b0;
            mepc_v         <= '0;
            mcause_v       <= '0;
            redirect_pc    <= '0;
        end else begin
            // Pulses default low; values hold until the next update
            panic          <= 1'b0;
            wMepc          <= 1'b0;
            wMcause        <= 1'b0;
            pc_mret        <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (acc_irq || acc_ecall) begin
                        state       <= ST_ENTER;
                        trap_is_irq <= acc_irq;
                        busy        <= 1'b1;
                        panic       <= 1'b1;
                        wMepc       <= 1'b1;
                        wMcause     <= 1'b1;
                        mepc_v      <= commit_pc;
                        mcause_v    <= acc_irq ? IRQ_MCAUSE : ECALL_MCAUSE;
                    end else if (acc_mret) begin
                        state          <= ST_RET;
                        busy           <= 1'b1;
                        pc_mret        <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mepc_i;
                    end
                end
                ST_ENTER: begin
                    // mtvec is sampled now, after the CSR writes have landed
                    state          <= ST_REDIRECT;
                    busy           <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= trap_target;
                end
                ST_REDIRECT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_RET: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized commits, checked
// by a cycle-tagged scoreboard fed from a behavioural reference model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam logic [4:0] S_TRAP  = 5'b11100; // {panic,wMepc,wMcause,pc_mret,redirect_valid}
    localparam logic [4:0] S_MRET  = 5'b00011;
    localparam logic [4:0] S_REDIR = 5'b00001;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  strb;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        is_ecall;
    logic        is_mret;
    logic        irq_i;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic [63:0] mstatus_i;
    logic        take;
    logic        busy;
    logic        panic;
    logic        wMepc;
    logic [63:0] mepc_v;
    logic        wMcause;
    logic [63:0] mcause_v;
    logic        pc_mret;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    // model state
    bit   m_pending  = 0;
    bit   m_prev_irq = 0;
    int   m_free_at  = 0;
    int   m_redir_at = -1;
    bit   m_redir_irq = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .is_ecall(is_ecall), .is_mret(is_mret), .irq_i(irq_i), .mtvec_i(mtvec_i),
        .mepc_i(mepc_i), .mstatus_i(mstatus_i), .take(take), .busy(busy),
        .panic(panic), .wMepc(wMepc), .mepc_v(mepc_v), .wMcause(wMcause),
        .mcause_v(mcause_v), .pc_mret(pc_mret), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_target(input logic [63:0] mtvec, input bit irq);
        logic [63:0] base;
        base = mtvec & ~64'h3;
`ifdef TRAP_CTRL_VECTORED_EN
        if (irq && mtvec[1:0] == 2'b01) return base + 64'd28;
`endif
        if (irq) return base;
        return base;
    endfunction

    // reference model: decides accepts from the architectural rules
    always @(negedge clk) begin
        bit irq_t, ec, mr, edge_seen;
        if (rst) begin
            m_pending  = 0;
            m_prev_irq = 0;
            m_free_at  = 0;
            m_redir_at = -1;
            exp_q.delete();
        end else begin
            chk("busy", busy, (cyc < m_free_at));
            edge_seen = irq_i && !m_prev_irq;
            irq_t = 0; ec = 0; mr = 0;
            if (m_redir_at == cyc) begin
                exp_q.push_back('{cyc: cyc + 1, strb: S_REDIR, a: exp_target(mtvec_i, m_redir_irq), b: 64'd0});
                m_redir_at = -1;
            end
            if (cyc >= m_free_at && commit_valid) begin
                irq_t = m_pending && mstatus_i[3];
                ec    = !irq_t && is_ecall;
                mr    = !irq_t && !ec && is_mret;
                if (irq_t || ec) begin
                    exp_q.push_back('{cyc: cyc + 1, strb: S_TRAP, a: commit_pc,
                                      b: irq_t ? 64'h8000_0000_0000_0007 : 64'd11});
                    m_redir_at  = cyc + 1;
                    m_redir_irq = irq_t;
                    m_free_at   = cyc + 3;
                end else if (mr) begin
                    exp_q.push_back('{cyc: cyc + 1, strb: S_MRET, a: mepc_i, b: 64'd0});
                    m_free_at = cyc + 2;
                end
            end
            chk("take", take, irq_t | ec | mr);
            m_pending  = edge_seen || (m_pending && !irq_t);
            m_prev_irq = irq_i;
        end
    end

    // monitor: pops an expectation whenever the DUT strobes anything
    always @(negedge clk) begin
        logic [4:0] strb;
        exp_t e;
        strb = {panic, wMepc, wMcause, pc_mret, redirect_valid};
        if (!rst) begin
            if (strb != 5'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 64'(strb), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ev_strobes", 64'(strb), 64'(e.strb));
                    if (e.strb == S_TRAP) begin
                        chk("mepc_v", mepc_v, e.a);
                        chk("mcause_v", mcause_v, e.b);
                    end else begin
                        chk("redirect_pc", redirect_pc, e.a);
                    end
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0].cyc) <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_event", 64'd0, 64'(e.strb));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid = 0; is_ecall = 0; is_mret = 0;
    endtask

    task automatic commit(input logic [63:0] pc, input bit ec, input bit mr);
        commit_valid = 1; commit_pc = pc; is_ecall = ec; is_mret = mr;
    endtask

    initial begin
        logic [63:0] vec_exp;
        rst = 1; idle_inputs(); commit_pc = 0; irq_i = 0;
        mtvec_i = 64'h8000_1000; mepc_i = 0; mstatus_i = 64'h8;
        repeat (3) step();
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {panic, wMepc, wMcause, pc_mret, redirect_valid}, 0);
        chk("rst_mepc_v", mepc_v, 0);
        chk("rst_mcause_v", mcause_v, 0);
        chk("rst_redirect_pc", redirect_pc, 0);

        // ecall into mtvec with mode bits set
        step();
        mtvec_i = 64'h8000_1003;
        commit(64'h8000_0010, 1, 0);
        #1 chk("ecall_take", take, 1);
        step(); idle_inputs();
        chk("ecall_wMepc", {panic, wMepc, wMcause}, 3'b111);
        chk("ecall_mepc_v", mepc_v, 64'h8000_0010);
        chk("ecall_mcause_v", mcause_v, 64'd11);
        step();
        chk("ecall_redirect", {redirect_valid, redirect_pc}, {1'b1, 64'h8000_1000});
        step();
        chk("ecall_busy_low", busy, 0);

        // mret back to mepc
        mepc_i = 64'h8000_0014;
        commit(64'h8000_0100, 0, 1);
        step(); idle_inputs();
        chk("mret_pulse", {pc_mret, redirect_valid}, 2'b11);
        chk("mret_pc", redirect_pc, 64'h8000_0014);
        step();
        chk("mret_busy_low", busy, 0);

        // interrupt masked for 10 commits, then taken once MIE is set
        mstatus_i = 64'h0; irq_i = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            commit(64'h8000_0200 + 64'(4 * i), 0, 0);
            #1 chk("masked_no_take", take, 0);
        end
        step();
        mstatus_i = 64'h8;
        commit(64'h8000_0300, 0, 0);
        #1 chk("irq_take", take, 1);
        step(); idle_inputs();
        chk("irq_mcause", mcause_v, 64'h8000_0000_0000_0007);
        chk("irq_mepc", mepc_v, 64'h8000_0300);
        repeat (2) step();
        commit(64'h8000_0304, 0, 0);
        #1 chk("irq_cleared", take, 0);
        step(); idle_inputs();

        // interrupt and ecall on the same commit; ecall replays afterwards
        irq_i = 0; step(); irq_i = 1; step();
        commit(64'h8000_0400, 1, 0);
        step(); idle_inputs();
        chk("irq_wins", mcause_v, 64'h8000_0000_0000_0007);
        repeat (2) step();
        commit(64'h8000_0400, 1, 0);
        step(); idle_inputs();
        chk("ecall_replay", mcause_v, 64'd11);
        repeat (2) step();

        // vectored-mode mtvec: interrupt, then ecall
`ifdef TRAP_CTRL_VECTORED_EN
        vec_exp = 64'h8000_101C;
`else
        vec_exp = 64'h8000_1000;
`endif
        mtvec_i = 64'h8000_1001;
        irq_i = 0; step(); irq_i = 1; step();
        commit(64'h8000_0500, 0, 0);
        step(); idle_inputs();
        step();
        chk("vec_irq_target", redirect_pc, vec_exp);
        step();
        commit(64'h8000_0504, 1, 0);
        step(); idle_inputs();
        step();
        chk("vec_ecall_target", redirect_pc, 64'h8000_1000);
        step();

        // asynchronous reset while in ENTER
        commit(64'h8000_0600, 1, 0);
        step(); idle_inputs();
        #2 rst = 1;
        #1;
        chk("midrst_outputs", {busy, panic, wMepc, wMcause, pc_mret, redirect_valid}, 0);
        chk("midrst_values", mepc_v | mcause_v | redirect_pc, 0);
        chk("midrst_state", 64'(dut.state), 64'(ST_IDLE));
        step();
        rst = 0;
        step();
        chk("midrst_no_redirect", redirect_valid, 0);
        repeat (3) step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            step();
            r = $urandom_range(0, 99);
            commit_valid = ($urandom_range(0, 1) == 1);
            is_ecall = (r < 15);
            is_mret  = (r >= 10 && r < 30);
            commit_pc = {$urandom, $urandom} & ~64'h3;
            mepc_i    = {$urandom, $urandom} & ~64'h3;
            mtvec_i   = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom};
            if ($urandom_range(0, 9) == 0) irq_i = ~irq_i;
            if ((i % 50) == 0) mstatus_i = {$urandom, $urandom} & ~64'h8 |
                                           (($urandom_range(0, 3) != 0) ? 64'h8 : 64'h0);
        end
        step(); idle_inputs();
        repeat (6) step();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // absolute time bound
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/return sequencer sitting directly upstream of the CSR register block.
- Watches the retiring instruction (ecall/mret) and a machine-timer interrupt line.
- Drives the CSR side-band writes (mepc, mcause, mstatus panic/mret) and redirects fetch to mtvec on entry, or to mepc on return.
- Stalls the core while the sequence runs.

Parameters:
- XLEN, 64, data/PC width.
- ECALL_CAUSE, 11, mcause value for an M-mode ecall.
- IRQ_CAUSE, 7, mcause low bits for the machine timer interrupt; bit XLEN-1 is set for interrupts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- commit_valid  in  1  instruction at commit_pc is retiring this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- is_ecall  in  1  retiring instruction is ecall (qualified by commit_valid).
- is_mret  in  1  retiring instruction is mret (qualified by commit_valid).
- irq_i  in  1  machine timer interrupt level.
- mtvec_i  in  XLEN  current mtvec from the CSR block.
- mepc_i  in  XLEN  current mepc from the CSR block.
- mstatus_i  in  XLEN  current mstatus; bit 3 = MIE.
- take  out  1  combinational; a trap or mret is accepted this cycle. On an interrupt the core squashes commit_pc's writeback.
- busy  out  1  registered; core must hold fetch/commit.
- panic  out  1  one-cycle pulse to CSR mstatus trap update.
- wMepc  out  1  mepc write strobe.
- mepc_v  out  XLEN  mepc write value.
- wMcause  out  1  mcause write strobe.
- mcause_v  out  XLEN  mcause write value.
- pc_mret  out  1  one-cycle pulse to CSR mstatus restore.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- FSM states: IDLE, ENTER, REDIRECT, RET.
- Reset (async, any state, mid-sequence included):
  - state = IDLE, irq_pending = 0.
  - All registered outputs 0: busy, panic, wMepc, wMcause, pc_mret, redirect_valid, mepc_v, mcause_v, redirect_pc.
- irq_pending: set on a rising edge of irq_i (registered previous sample); cleared when the interrupt is taken. Set wins over clear only if a new edge arrives in the same cycle as the take.
- Accept conditions, IDLE only. Priority: interrupt > ecall > mret.
  - Interrupt: irq_pending && mstatus_i[3] && commit_valid. Then mepc_v = commit_pc, mcause_v = {1'b1, IRQ_CAUSE}.
  - Ecall: commit_valid && is_ecall. Then mepc_v = commit_pc, mcause_v = ECALL_CAUSE.
  - Mret: commit_valid && is_mret && !is_ecall.
  - is_ecall && is_mret together is treated as ecall.
- take is high combinationally in the accept cycle; the registered outputs update at that edge.
- ENTER (1 cycle): panic = wMepc = wMcause = 1, busy = 1; next state is REDIRECT.
- REDIRECT (1 cycle): redirect_valid = 1, redirect_pc = {mtvec_i[XLEN-1:2], 2'b00}, busy = 1; next state is IDLE. mtvec is sampled here, after the CSR writes land.
- RET (1 cycle): pc_mret = 1, redirect_valid = 1, redirect_pc = mepc_i, busy = 1; next state is IDLE.
- Latency: accept at edge N; strobes visible in cycle N+1; redirect in N+2 for traps and N+1 for mret.
- commit_valid while busy = 1 is ignored (no accept, no pending change other than edge capture).
- MIE = 0: the interrupt stays pending until MIE = 1 and a commit occurs.
- Back-to-back traps are allowed: a new accept is possible in the first cycle after returning to IDLE.

Optional Feature:
- Macro: TRAP_CTRL_VECTORED_EN.
- Defined: when mtvec_i[1:0] == 2'b01 and the trap is an interrupt, redirect_pc = base + 4*IRQ_CAUSE. Exceptions still use base.
- Undefined: mtvec_i[1:0] is always ignored (direct mode).

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - ECALL_CAUSE / IRQ_CAUSE defaults.
  - MSTATUS_MIE_BIT = 3, alongside the existing CSR address constants.
- No sub-module needed; the irq edge detector is two flops inline.

Test Plan:
- Reset mid-ENTER (assert rst async) -> all outputs 0 immediately, state IDLE, no redirect follows.
- commit_valid=1, is_ecall=1, commit_pc=0x80000010, mtvec_i=0x80001003 -> take in cycle N; cycle N+1 wMepc=wMcause=panic=1, mepc_v=0x80000010, mcause_v=11; cycle N+2 redirect_pc=0x80001000.
- is_mret=1, mepc_i=0x80000014 -> cycle N+1 pc_mret=1, redirect_valid=1, redirect_pc=0x80000014; busy low in N+2.
- irq_i rises, mstatus_i[3]=0 for 10 commits -> no take; MIE set -> next commit taken, mcause_v=0x8000000000000007, mepc_v=commit_pc, pending cleared.
- irq pending + is_ecall same commit -> interrupt wins (mcause bit63=1); ecall at commit_pc replays later.
- With TRAP_CTRL_VECTORED_EN, mtvec_i=0x80001001, interrupt -> redirect_pc=0x8000101C; ecall -> 0x80001000.
